memory_master: RTL

- Bus master for the shared-bus N-bit x 2^M register memory.
- Takes single-beat read/write requests on a valid/ready handshake and sequences the memory's Select/RW/DataBus protocol.
- Drives DataBus only during the write-data phase and returns one response per request.
- Sits between the CPU/datapath request logic and the memory instance; connects to it port-for-port.

---
 rtl/memory_pkg.sv | 16 +
 rtl/memory_master.sv | 96 +++++++++
 2 files changed

// File: rtl/memory_pkg.sv
// Shared constants for the register memory and its bus master: default sizes,
// master state encoding and the RW line encoding.
package memory_pkg;

    localparam int MEM_N = 8;
    localparam int MEM_M = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/memory_master.sv
// Single-beat bus master for the shared-bus register memory: one request in,
// address phase, data phase, one response out (3 cycles per transaction).
module memory_master
    import memory_pkg::*;
#(
    parameter int N = MEM_N,
    parameter int M = MEM_M
) (
    input  logic         Clock,
    input  logic         ResetN,
    // Handshake: a request transfers on a posedge where ReqValid && ReqReady;
    // the requester holds ReqAddr/ReqData/ReqWrite stable until then. RspValid
    // is a one-cycle pulse with no back-pressure.
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic [M-1:0] ReqAddr,
    input  logic [N-1:0] ReqData,
    output logic         RspValid,
    output logic [N-1:0] RspData,
    output logic [M-1:0] Select,
    output logic         RW,
    inout  wire  [N-1:0] DataBus,
    output logic [1:0]   DbgState
);

    logic [1:0]   state_q, state_d;
    logic [M-1:0] addr_q, addr_d;
    logic [N-1:0] data_q, data_d;
    logic         wr_q, wr_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    data_d  = ReqData;
                    wr_d    = ReqWrite;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = wr_q ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_q;
                state_d     = ST_IDLE;
            end
            ST_READ: begin
                // Captured unfiltered: whatever the memory has on the bus.
                rsp_valid_d = 1'b1;
                rsp_data_d  = DataBus;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // RW and bus ownership both decode the registered state, so they switch
    // together and the memory never drives while the master does.
    assign RW       = (state_q == ST_WRITE) ? RW_WRITE : RW_READ;
    assign DataBus  = (state_q == ST_WRITE) ? data_q : {N{1'bz}};
    assign Select   = addr_q;
    assign ReqReady = (state_q == ST_IDLE);
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign DbgState = state_q;

endmodule
